// File: rtl/uart_apb_master_pkg.sv
// Shared definitions for uart_apb_master: UART register offsets, SR bit indices, FSM states.
package uart_apb_master_pkg;

    localparam logic [5:0] ADDR_CR   = 6'h04;
    localparam logic [5:0] ADDR_THR  = 6'h08;
    localparam logic [5:0] ADDR_RHR  = 6'h08;
    localparam logic [5:0] ADDR_SR   = 6'h0C;
    localparam logic [5:0] ADDR_BRGR = 6'h10;
    localparam logic [5:0] ADDR_IMR  = 6'h14;

    localparam int unsigned SR_TX_BUSY  = 0;
    localparam int unsigned SR_RX_VALID = 1;
    localparam int unsigned SR_PERR     = 2;

    typedef enum logic [2:0] {
        INIT_CR,
        INIT_BRGR,
        INIT_IMR,
        POLL_SR,
        RD_RHR,
        WR_THR
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ACCESS
    } phase_t;

endpackage

// File: rtl/uart_apb_master_apb_xfer.sv
// Single APB transfer sequencer: SETUP then ACCESS, zero wait states, back-to-back capable.
module apb_xfer
    import uart_apb_master_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  addr,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [5:0]  paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata
);

    phase_t phase, phase_next;
    logic   load;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase  <= PH_IDLE;
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else begin
            phase <= phase_next;
            if (load) begin
                pwrite <= write;
                paddr  <= addr;
                pwdata <= wdata;
            end
        end
    end

    // A new request is taken in the ACCESS cycle so the next SETUP follows with no idle gap.
    always_comb begin
        phase_next = phase;
        load       = 1'b0;
        unique case (phase)
            PH_IDLE, PH_ACCESS: begin
                phase_next = PH_IDLE;
                if (start) begin
                    phase_next = PH_SETUP;
                    load       = 1'b1;
                end
            end
            PH_SETUP: phase_next = PH_ACCESS;
            default:  phase_next = PH_IDLE;
        endcase
    end

    assign psel    = (phase != PH_IDLE);
    assign penable = (phase == PH_ACCESS);
    assign done    = (phase == PH_ACCESS);
    assign rdata   = prdata;

endmodule

// File: rtl/uart_apb_master.sv
// APB initiator driving the UART register block; optional SR parity-error counter via UART_APB_MASTER_ERRCNT_EN.
module uart_apb_master
    import uart_apb_master_pkg::*;
#(
    parameter logic [31:0] CR_INIT   = 32'h0000_0000,
    parameter logic [31:0] BRGR_INIT = 32'h0000_0000,
    parameter logic [31:0] IMR_INIT  = 32'h0000_0000
) (
    input  logic        pclk_i,
    input  logic        preset_i,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [5:0]  paddr_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        perr_o
`ifdef UART_APB_MASTER_ERRCNT_EN
    ,
    output logic [7:0]  perr_cnt_o
`endif
);

    state_t      state, state_next, req_state;
    logic [5:0]  req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        done;
    logic [31:0] rdata;
    logic        full;
    logic [7:0]  hold;
    logic        sr_done;
    logic        unused_rdata;

    assign sr_done      = done && (state == POLL_SR);
    assign tx_ready_o   = !full;
    assign unused_rdata = ^rdata[31:8];

    apb_xfer u_xfer (
        .clk     (pclk_i),
        .rst     (preset_i),
        .start   (1'b1),
        .addr    (req_addr),
        .write   (req_write),
        .wdata   (req_wdata),
        .done    (done),
        .rdata   (rdata),
        .psel    (psel_o),
        .penable (penable_o),
        .pwrite  (pwrite_o),
        .paddr   (paddr_o),
        .pwdata  (pwdata_o),
        .prdata  (prdata_i)
    );

    always_ff @(posedge pclk_i) begin
        if (preset_i) state <= INIT_CR;
        else          state <= state_next;
    end

    // During ACCESS the request already describes the following state's transfer.
    always_comb begin
        state_next = state;
        if (done) begin
            unique case (state)
                INIT_CR:   state_next = INIT_BRGR;
                INIT_BRGR: state_next = INIT_IMR;
                INIT_IMR:  state_next = POLL_SR;
                POLL_SR: begin
                    if (rdata[SR_RX_VALID] && !rx_valid_o)   state_next = RD_RHR;
                    else if (full && !rdata[SR_TX_BUSY])     state_next = WR_THR;
                    else                                     state_next = POLL_SR;
                end
                default:   state_next = POLL_SR;
            endcase
        end
        req_state = done ? state_next : state;

        req_addr  = ADDR_SR;
        req_write = 1'b0;
        req_wdata = '0;
        unique case (req_state)
            INIT_CR:   begin req_addr = ADDR_CR;   req_write = 1'b1; req_wdata = CR_INIT;   end
            INIT_BRGR: begin req_addr = ADDR_BRGR; req_write = 1'b1; req_wdata = BRGR_INIT; end
            INIT_IMR:  begin req_addr = ADDR_IMR;  req_write = 1'b1; req_wdata = IMR_INIT;  end
            RD_RHR:    req_addr = ADDR_RHR;
            WR_THR:    begin req_addr = ADDR_THR;  req_write = 1'b1; req_wdata = {24'h0, hold}; end
            default:   req_addr = ADDR_SR;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            full       <= 1'b0;
            hold       <= '0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
            perr_o     <= 1'b0;
        end else begin
            if (tx_valid_i && !full) begin
                full <= 1'b1;
                hold <= tx_data_i;
            end else if (done && state == WR_THR) begin
                full <= 1'b0;
            end

            if (done && state == RD_RHR) begin
                rx_valid_o <= 1'b1;
                rx_data_o  <= rdata[7:0];
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end

            if (sr_done && rdata[SR_PERR]) perr_o <= 1'b1;
        end
    end

`ifdef UART_APB_MASTER_ERRCNT_EN
    always_ff @(posedge pclk_i) begin
        if (preset_i)
            perr_cnt_o <= '0;
        else if (sr_done && rdata[SR_PERR] && perr_cnt_o != 8'hFF)
            perr_cnt_o <= perr_cnt_o + 8'd1;
    end
`endif

endmodule

// File: tb/tb_uart_apb_master.sv
// Self-checking bench for uart_apb_master: APB slave model, transfer log and byte-stream scoreboard.
`timescale 1ns/1ps
module tb_uart_apb_master;

    logic        pclk = 1'b0;
    logic        preset_i;
    logic        psel_o, penable_o, pwrite_o;
    logic [5:0]  paddr_o;
    logic [31:0] pwdata_o, prdata_i;
    logic [7:0]  tx_data_i;
    logic        tx_valid_i, tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o, rx_ready_i, perr_o;
`ifdef UART_APB_MASTER_ERRCNT_EN
    logic [7:0]  perr_cnt_o;
`endif

    logic [31:0] sr_val, rhr_val;

    always #5 pclk = ~pclk;

    uart_apb_master #(
        .CR_INIT   (32'h0000_0003),
        .BRGR_INIT (32'h0010_0036),
        .IMR_INIT  (32'h0000_0001)
    ) dut (
        .pclk_i     (pclk),
        .preset_i   (preset_i),
        .psel_o     (psel_o),
        .penable_o  (penable_o),
        .pwrite_o   (pwrite_o),
        .paddr_o    (paddr_o),
        .pwdata_o   (pwdata_o),
        .prdata_i   (prdata_i),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .perr_o     (perr_o)
`ifdef UART_APB_MASTER_ERRCNT_EN
        ,
        .perr_cnt_o (perr_cnt_o)
`endif
    );

    // Zero-wait-state slave: SR at 0x0C, RHR at 0x08.
    assign prdata_i = (paddr_o == 6'h0C) ? sr_val :
                      (paddr_o == 6'h08) ? rhr_val : 32'hDEAD_BEEF;

    typedef struct {
        logic [5:0]  addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned cyc;
    } rec_t;

    rec_t        xq[$];
    logic [7:0]  acc_q[$];
    logic [7:0]  got_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        prev_setup = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    function automatic int count_recs(input int from, input logic [5:0] a, input logic w);
        int n = 0;
        for (int k = from; k < xq.size(); k++)
            if (xq[k].addr == a && xq[k].write == w) n++;
        return n;
    endfunction

    function automatic int find_rec(input int from, input logic [5:0] a, input logic w);
        for (int k = from; k < xq.size(); k++)
            if (xq[k].addr == a && xq[k].write == w) return k;
        return -1;
    endfunction

    task automatic wait_rec(input string tag, input logic [5:0] a, input logic w,
                            input int from, input int budget, output int idx);
        int n = 0;
        idx = find_rec(from, a, w);
        while (idx < 0 && n < budget) begin
            tick();
            n++;
            idx = find_rec(from, a, w);
        end
        if (idx < 0) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    // Transfer log and stream handshakes, sampled at the rising edge before outputs update.
    always @(posedge pclk) begin
        cyc = cyc + 1;
        if (!preset_i) begin
            if (psel_o && penable_o) begin
                check("access_follows_setup", {31'b0, prev_setup}, 32'd1);
                if (paddr_o == 6'h08 && !pwrite_o)
                    check("rhr_read_while_rx_full", {31'b0, rx_valid_o}, 32'd0);
                xq.push_back('{paddr_o, pwrite_o, pwdata_o, prdata_i, cyc});
            end
            if (tx_valid_i && tx_ready_o) acc_q.push_back(tx_data_i);
            if (rx_valid_o && rx_ready_i) got_q.push_back(rx_data_o);
        end
        prev_setup = psel_o && !penable_o && !preset_i;
    end

    initial begin
        int          mark, idx, ir, iw, ff, n, prev;
        logic [5:0]  init_addr [3];
        logic [31:0] init_data [3];
        logic [31:0] thr_q[$];
        logic [7:0]  srv_q[$];

        init_addr = '{6'h04, 6'h10, 6'h14};
        init_data = '{32'h0000_0003, 32'h0010_0036, 32'h0000_0001};

        preset_i = 1'b1; tx_valid_i = 1'b0; tx_data_i = '0; rx_ready_i = 1'b0;
        sr_val = '0; rhr_val = '0;
        repeat (3) @(negedge pclk);

        check("rst_apb_ctl",  {29'b0, psel_o, penable_o, pwrite_o}, 32'd0);
        check("rst_paddr",    {26'b0, paddr_o}, 32'd0);
        check("rst_pwdata",   pwdata_o, 32'd0);
        check("rst_rx",       {23'b0, rx_valid_o, rx_data_o}, 32'd0);
        check("rst_perr",     {31'b0, perr_o}, 32'd0);
        check("rst_tx_ready", {31'b0, tx_ready_o}, 32'd1);

        // Init sequence
        preset_i = 1'b0;
        tick();
        check("cr_setup_ctl",  {29'b0, psel_o, penable_o, pwrite_o}, 32'b101);
        check("cr_setup_addr", {26'b0, paddr_o}, 32'h04);
        check("cr_setup_data", pwdata_o, 32'h3);
        repeat (6) tick();
        check("sr_setup_ctl",  {29'b0, psel_o, penable_o, pwrite_o}, 32'b100);
        check("sr_setup_addr", {26'b0, paddr_o}, 32'h0C);
        check("init_count",    xq.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("init_addr",  {26'b0, xq[i].addr}, {26'b0, init_addr[i]});
            check("init_write", {31'b0, xq[i].write}, 32'd1);
            check("init_data",  xq[i].wdata, init_data[i]);
        end
        check("init_spacing", xq[2].cyc - xq[0].cyc, 32'd4);

        // TX byte through THR
        mark = xq.size();
        tx_data_i = 8'hA5; tx_valid_i = 1'b1; tick(); tx_valid_i = 1'b0;
        check("tx_ready_drop", {31'b0, tx_ready_o}, 32'd0);
        wait_rec("thr_a5", 6'h08, 1'b1, mark, 40, idx);
        if (idx > 0) begin
            check("thr_a5_data", xq[idx].wdata, 32'h0000_00A5);
            check("thr_after_sr", {25'b0, xq[idx-1].addr, xq[idx-1].write}, {25'b0, 6'h0C, 1'b0});
        end
        check("tx_ready_return", {31'b0, tx_ready_o}, 32'd1);

        // TX held while UART busy
        sr_val = 32'h1; mark = xq.size();
        tx_data_i = 8'h5A; tx_valid_i = 1'b1; tick(); tx_valid_i = 1'b0;
        n = 0;
        while (count_recs(mark, 6'h0C, 1'b0) < 5 && n < 100) begin tick(); n++; end
        check("busy_polls", (count_recs(mark, 6'h0C, 1'b0) >= 5) ? 32'd1 : 32'd0, 32'd1);
        sr_val = 32'h0;
        wait_rec("thr_busy", 6'h08, 1'b1, mark, 40, idx);
        ff = -1;
        for (int k = mark; k < xq.size(); k++)
            if (ff < 0 && xq[k].addr == 6'h0C && !xq[k].write && !xq[k].rdata[0]) ff = k;
        check("thr_after_busy_clear", idx, ff + 1);
        if (idx >= 0) check("thr_busy_data", xq[idx].wdata, 32'h0000_005A);

        // RX back-pressure
        sr_val = 32'h2; rhr_val = 32'h0000_003C; rx_ready_i = 1'b0; mark = xq.size();
        for (int i = 0; i < 20; i++) begin
            prev = xq.size();
            tick();
            if (xq.size() > prev && xq[xq.size()-1].addr == 6'h08 && !xq[xq.size()-1].write)
                check("rx_valid_rise", {31'b0, rx_valid_o}, 32'd1);
        end
        check("rhr_reads_once", count_recs(mark, 6'h08, 1'b0), 32'd1);
        check("rx_data_held", {23'b0, rx_valid_o, rx_data_o}, {23'b0, 1'b1, 8'h3C});
        sr_val = 32'h0; rx_ready_i = 1'b1; tick(); rx_ready_i = 1'b0;
        check("rx_accept_clears", {31'b0, rx_valid_o}, 32'd0);

        // SR=3: RHR read wins while TX is busy, THR follows once busy drops
        sr_val = 32'h3; rhr_val = 32'h0000_0011; mark = xq.size();
        tx_data_i = 8'hC3; tx_valid_i = 1'b1; tick(); tx_valid_i = 1'b0;
        wait_rec("rhr_sr3", 6'h08, 1'b0, mark, 40, ir);
        sr_val = 32'h2;
        wait_rec("thr_sr3", 6'h08, 1'b1, mark, 40, iw);
        check("rhr_before_thr", (ir >= 0 && ir < iw) ? 32'd1 : 32'd0, 32'd1);
        rx_ready_i = 1'b1; tick(); rx_ready_i = 1'b0;

        // Same-poll priority: SR=2 with TX held and RX empty
        sr_val = 32'h0; tick(); tick();
        sr_val = 32'h2; mark = xq.size();
        tx_data_i = 8'h3D; tx_valid_i = 1'b1; tick(); tx_valid_i = 1'b0;
        wait_rec("thr_sr2", 6'h08, 1'b1, mark, 40, iw);
        ir = find_rec(mark, 6'h08, 1'b0);
        check("sr2_rhr_first", (ir >= 0 && iw == ir + 2) ? 32'd1 : 32'd0, 32'd1);
        sr_val = 32'h0; rx_ready_i = 1'b1; tick(); rx_ready_i = 1'b0;

        // Sticky parity error
        check("perr_clear", {31'b0, perr_o}, 32'd0);
        sr_val = 32'h4; mark = xq.size();
        wait_rec("sr_perr", 6'h0C, 1'b0, mark, 20, idx);
        sr_val = 32'h0;
        check("perr_set", {31'b0, perr_o}, 32'd1);
`ifdef UART_APB_MASTER_ERRCNT_EN
        check("perr_cnt_one", {24'b0, perr_cnt_o}, 32'd1);
`endif
        repeat (10) tick();
        check("perr_sticky", {31'b0, perr_o}, 32'd1);

        // Randomized traffic against a stream-order scoreboard
        acc_q.delete(); got_q.delete(); mark = xq.size();
        for (int i = 0; i < 600; i++) begin
            sr_val     = {30'b0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0)};
            rhr_val    = $urandom;
            rx_ready_i = ($urandom_range(0, 2) != 0);
            tx_valid_i = $urandom_range(0, 1);
            tx_data_i  = 8'($urandom);
            tick();
        end
        tx_valid_i = 1'b0; sr_val = 32'h0; rx_ready_i = 1'b1;
        repeat (40) tick();
        rx_ready_i = 1'b0;
        for (int k = mark; k < xq.size(); k++) begin
            if (xq[k].addr == 6'h08 && xq[k].write)  thr_q.push_back(xq[k].wdata);
            if (xq[k].addr == 6'h08 && !xq[k].write) srv_q.push_back(xq[k].rdata[7:0]);
        end
        check("rand_tx_count", thr_q.size(), acc_q.size());
        for (int k = 0; k < thr_q.size() && k < acc_q.size(); k++)
            check("rand_tx_byte", thr_q[k], {24'h0, acc_q[k]});
        check("rand_rx_count", got_q.size(), srv_q.size());
        for (int k = 0; k < got_q.size() && k < srv_q.size(); k++)
            check("rand_rx_byte", {24'h0, got_q[k]}, {24'h0, srv_q[k]});

        // Reset during THR ACCESS
        sr_val = 32'h0;
        tx_data_i = 8'h77; tx_valid_i = 1'b1; tick(); tx_valid_i = 1'b0;
        n = 0;
        while (!(psel_o && penable_o && pwrite_o && paddr_o == 6'h08) && n < 40) begin tick(); n++; end
        check("thr_access_reached", {31'b0, (psel_o && penable_o && pwrite_o && paddr_o == 6'h08)}, 32'd1);
        preset_i = 1'b1; mark = xq.size(); tick();
        check("mid_rst_psel",     {31'b0, psel_o}, 32'd0);
        check("mid_rst_tx_ready", {31'b0, tx_ready_o}, 32'd1);
        check("mid_rst_rx_valid", {31'b0, rx_valid_o}, 32'd0);
        preset_i = 1'b0; tick();
        check("reinit_setup_addr", {26'b0, paddr_o}, 32'h04);
        repeat (14) tick();
        check("abandoned_thr_absent", count_recs(mark, 6'h08, 1'b1), 32'd0);
        for (int i = 0; i < 3; i++)
            check("reinit_addr", {26'b0, xq[mark+i].addr}, {26'b0, init_addr[i]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
